result_checker_param: RTL
=========================

Name: result_checker_param

Overview:
- Parametrised simulation-side result checker for the RISC-V pipeline CPU; snoops the data-memory write bus.
- Arms on a begin-symbol write to a configurable test port, then compares each later test-port write against an expected-value table.
- Expected values are loaded at runtime through a load port instead of a hard-coded ROM.
- Reports error count, duration, first-mismatch details, finish and timeout.

Parameters:
- ADDR_W, 30, width of bus word address.
- DATA_W, 32, width of bus data; must be a multiple of 8.
- DEPTH, 32, number of expected-value entries; power of 2.
- TEST_PORT, 30'h10, word address monitored.
- BEGIN_SYM, 32'h00000168, value that arms checking.
- SWAP_BYTES, 1, 1 = byte-reverse bus data before any compare (little-endian to readable); 0 = compare raw.
- TIMEOUT, 16'hFFF0, CHECK-state cycle limit before forced finish.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- addr  in  ADDR_W  bus word address.
- data  in  DATA_W  bus write data.
- wen  in  1  bus write enable; may be held several cycles during a D-cache stall.
- exp_we  in  1  expected-table write strobe.
- exp_idx  in  log2(DEPTH)  expected-table index.
- exp_data  in  DATA_W  expected value (already in readable byte order).
- num_checks  in  log2(DEPTH)+1  number of compares to perform; sampled when leaving IDLE.
- error_num  out  8  mismatch count; 255 until armed.
- duration  out  16  CHECK-state cycles.
- finish  out  1  high in REPORT or TIMEOUT.
- timed_out  out  1  high in TIMEOUT.
- first_err_idx  out  log2(DEPTH)+1  index of first mismatch; all-ones if none.
- first_err_data  out  DATA_W  observed value at first mismatch; 0 if none.

Behaviour:
- Reset (async, rst=1): state=IDLE, error_num=255, duration=0, finish=0, timed_out=0, first_err_idx=all-ones, first_err_data=0, compare index=0, arm flag=1. The expected table is not cleared. Reset mid-check aborts immediately.
- Data path: d = SWAP_BYTES ? byte-reversed data : data.
- Write acceptance (dedup): a write is accepted only when wen=1 and arm=1.
  - Accepting a write clears arm; wen=0 sets arm.
  - arm is tracked in every state, so a write held N cycles is seen once.
- Test write: an accepted write with addr==TEST_PORT.
- IDLE:
  - exp_we writes table[exp_idx]=exp_data.
  - A test write with d==BEGIN_SYM → CHECK next cycle. That cycle: error_num←0, duration←0, index←0, num_checks latched.
  - A latched num_checks of 0 goes straight to REPORT.
- CHECK:
  - duration increments every cycle, saturating at 16'hFFFF.
  - exp_we is ignored.
  - Per test write: compare d with table[index], then index←index+1.
  - On mismatch, error_num increments, saturating at 255.
  - On the first mismatch only, capture first_err_idx←index and first_err_data←d.
- CHECK exits, in priority order:
  1. index reaches latched num_checks (evaluated on the registered index, i.e. the cycle after the last compare) → REPORT.
  2. Otherwise duration==TIMEOUT → TIMEOUT.
- REPORT: finish=1; all outputs frozen; remain until reset.
- TIMEOUT: finish=1, timed_out=1; outputs frozen; remain until reset.
- Non-test-port writes never affect compare state, but do consume arm.
- If a test write and index==num_checks coincide, the state exits first and the write is ignored.
- Outputs are registered; finish and timed_out are decoded from the state register.

Test Plan:
- Pass path: load table[0..2]={0x1234,0xABCD,0xFFFFFD5D}, num_checks=3. Begin write 0x68010000 raw with SWAP_BYTES=1, then three matching raw writes → REPORT, finish=1, error_num=0, first_err_idx=all-ones.
- Stall dedup: hold wen=1 for 4 cycles on each test write → each counted once; error_num=0, index advances by 1 per burst.
- Mismatch capture: entry 1 expects 0xABCD, send 0xABCE → error_num=1, first_err_idx=1, first_err_data=0xABCE. A second mismatch at entry 2 → error_num=2, capture unchanged.
- Timeout: TIMEOUT=20, arm, send no writes → timed_out=1 and finish=1 with duration=20; error_num=0.
- Gating: write to addr 0x11 during CHECK → ignored. exp_we during CHECK → table unchanged. Begin value before arming on a non-test address → stays IDLE, error_num=255.
- Reset mid-CHECK: assert rst after 2 compares → IDLE, error_num=255, duration=0. Re-arm and rerun → correct result using the retained table.

Source files
------------

// File: rtl/result_checker_param.sv
// -----------------------------------------------------------------------------
// result_checker_param
//
// Simulation-side result checker for the RISC-V pipeline CPU. It snoops the
// data-memory write bus. A write of BEGIN_SYM to TEST_PORT arms the checker.
// After that, each write to TEST_PORT is compared against an expected-value
// table, which is loaded at runtime through the exp_* port. The checker
// reports the mismatch count, the CHECK duration, the first mismatch,
// completion and timeout.
//
// Ports:
//   clk            clock
//   rst            asynchronous active-high reset
//   addr/data/wen  snooped bus write (word address, data, write enable)
//   exp_we/exp_idx/exp_data  expected-table load port (honoured in IDLE only)
//   num_checks     number of compares, latched when the checker arms
//   error_num      mismatch count (255 until armed, saturating)
//   duration       cycles spent in CHECK (saturating)
//   finish         high in REPORT or TIMEOUT
//   timed_out      high in TIMEOUT
//   first_err_idx  index of first mismatch, all-ones if none
//   first_err_data observed value at first mismatch, 0 if none
// -----------------------------------------------------------------------------
module result_checker_param #(
  parameter int              ADDR_W     = 30,
  parameter int              DATA_W     = 32,
  parameter int              DEPTH      = 32,
  parameter logic [ADDR_W-1:0] TEST_PORT = 30'h10,
  parameter logic [DATA_W-1:0] BEGIN_SYM = 32'h00000168,
  parameter bit              SWAP_BYTES = 1'b1,
  parameter logic [15:0]     TIMEOUT    = 16'hFFF0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          data,
  input  logic                       wen,
  input  logic                       exp_we,
  input  logic [$clog2(DEPTH)-1:0]   exp_idx,
  input  logic [DATA_W-1:0]          exp_data,
  input  logic [$clog2(DEPTH):0]     num_checks,
  output logic [7:0]                 error_num,
  output logic [15:0]                duration,
  output logic                       finish,
  output logic                       timed_out,
  output logic [$clog2(DEPTH):0]     first_err_idx,
  output logic [DATA_W-1:0]          first_err_data
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = IDX_W + 1;
  localparam int NBYTES = DATA_W / 8;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_REPORT,
    S_TIMEOUT
  } state_t;

  state_t              state_reg, state_next;
  logic                arm_reg, arm_next;
  logic [CNT_W-1:0]    index_reg, index_next;
  logic [CNT_W-1:0]    num_reg, num_next;
  logic [7:0]          error_num_reg, error_num_next;
  logic [15:0]         duration_reg, duration_next;
  logic [CNT_W-1:0]    first_err_idx_reg, first_err_idx_next;
  logic [DATA_W-1:0]   first_err_data_reg, first_err_data_next;
  logic                table_we;

  logic [DATA_W-1:0]   table_mem [DEPTH];
  logic [DATA_W-1:0]   exp_val;
  logic [DATA_W-1:0]   d;
  logic                accept;
  logic                test_write;

  // Bus data is little-endian; optionally reverse bytes so that compares
  // happen in the readable order the expected table is written in.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_swap
      if (SWAP_BYTES) begin : g_rev
        assign d[gi*8 +: 8] = data[(NBYTES-1-gi)*8 +: 8];
      end else begin : g_raw
        assign d[gi*8 +: 8] = data[gi*8 +: 8];
      end
    end
  endgenerate

  // A write that is held across a D-cache stall is accepted only once.
  // arm re-opens only after wen drops.
  assign accept     = wen & arm_reg;
  assign test_write = accept && (addr == TEST_PORT);

  // The compare must happen in the same cycle as the bus write, so the
  // table is read combinationally at the registered compare index.
  assign exp_val = table_mem[index_reg[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (table_we) begin
      table_mem[exp_idx] <= exp_data;
    end
  end

  always_comb begin
    state_next          = state_reg;
    arm_next            = arm_reg;
    index_next          = index_reg;
    num_next            = num_reg;
    error_num_next      = error_num_reg;
    duration_next       = duration_reg;
    first_err_idx_next  = first_err_idx_reg;
    first_err_data_next = first_err_data_reg;
    table_we            = 1'b0;

    if (accept) begin
      arm_next = 1'b0;
    end else if (!wen) begin
      arm_next = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        table_we = exp_we;
        if (test_write && d == BEGIN_SYM) begin
          error_num_next = 8'd0;
          duration_next  = 16'd0;
          index_next     = '0;
          num_next       = num_checks;
          state_next     = (num_checks == '0) ? S_REPORT : S_CHECK;
        end
      end

      S_CHECK: begin
        // On an exit cycle every output freezes. A test write that lands
        // on that cycle is dropped.
        if (index_reg == num_reg) begin
          state_next = S_REPORT;
        end else if (duration_reg == TIMEOUT) begin
          state_next = S_TIMEOUT;
        end else begin
          if (duration_reg != 16'hFFFF) begin
            duration_next = duration_reg + 16'd1;
          end
          if (test_write) begin
            index_next = index_reg + CNT_ONE;
            if (d != exp_val) begin
              if (error_num_reg != 8'hFF) begin
                error_num_next = error_num_reg + 8'd1;
              end
              // The count starts at 0 and saturates, so 0 means this is
              // the first mismatch of the run.
              if (error_num_reg == 8'd0) begin
                first_err_idx_next  = index_reg;
                first_err_data_next = d;
              end
            end
          end
        end
      end

      default: begin
        // REPORT and TIMEOUT hold everything until reset.
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= S_IDLE;
      arm_reg            <= 1'b1;
      index_reg          <= '0;
      num_reg            <= '0;
      error_num_reg      <= 8'hFF;
      duration_reg       <= 16'd0;
      first_err_idx_reg  <= '1;
      first_err_data_reg <= '0;
    end else begin
      state_reg          <= state_next;
      arm_reg            <= arm_next;
      index_reg          <= index_next;
      num_reg            <= num_next;
      error_num_reg      <= error_num_next;
      duration_reg       <= duration_next;
      first_err_idx_reg  <= first_err_idx_next;
      first_err_data_reg <= first_err_data_next;
    end
  end

  assign error_num      = error_num_reg;
  assign duration       = duration_reg;
  assign first_err_idx  = first_err_idx_reg;
  assign first_err_data = first_err_data_reg;
  assign finish         = (state_reg == S_REPORT) || (state_reg == S_TIMEOUT);
  assign timed_out      = (state_reg == S_TIMEOUT);

endmodule
